tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer: the distribution end of a word-serial TDM link whose transmit end is built from the mux cells.
- Receives one word per valid cycle on a shared input, with a frame-sync marker on the channel-0 slot.
- Steers each word into a per-channel holding register, with a one-cycle valid strobe per channel.
- Hunts for, locks to and checks frame alignment.

Parameters:
N_CH, 4, number of TDM channels (slots per frame); legal range 2..16
W, 8, data word width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  W  incoming TDM word
in_valid  input  1  in_data carries a word this cycle
frame_sync  input  1  qualifies the current word as slot 0; ignored unless in_valid=1
out_data  output  N_CH*W  channel holding registers; channel k occupies bits [k*W +: W]
out_valid  output  N_CH  bit k pulses high one cycle when channel k register is updated
frame_done  output  1  one-cycle pulse when slot N_CH-1 is written
sync_err  output  1  one-cycle pulse on a detected alignment error
locked  output  1  high while in LOCKED state

Behaviour:
- Reset is asynchronous: on rst_n=0 all outputs are forced immediately, not at the next edge.
  - out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
  - State=HUNT, slot counter=0.
- Release is synchronous to the next clk edge.
- Slot counter width is clog2(N_CH). It counts 0..N_CH-1, then wraps to 0.
- Latency: a word accepted at edge t appears in out_data and asserts its out_valid bit in the cycle after edge t, i.e. one registered cycle. frame_done and sync_err have the same latency.
- All strobes are single-cycle pulses, cleared on the following edge unless re-triggered.
- At most one out_valid bit is high in any cycle.
- Cycles with in_valid=0 hold the state, the counter and all holding registers; strobes fall to 0.
- State HUNT:
  - in_valid=1 with frame_sync=0: word dropped, no strobes.
  - in_valid=1 with frame_sync=1: word written to channel 0, out_valid[0] pulses, counter becomes 1, state becomes LOCKED, locked=1 from that edge.
- State LOCKED, in_valid=1:
  - Counter=c≠0 and frame_sync=0: word written to channel c, out_valid[c] pulses. Counter becomes c+1, or wraps to 0 when c=N_CH-1. frame_done pulses when c=N_CH-1.
  - Counter=0 and frame_sync=1: normal frame start. Word written to channel 0, counter becomes 1.
  - Counter=0 and frame_sync=0 (missing sync): sync_err pulses, word dropped, state becomes HUNT, locked=0, counter=0.
  - Counter=c≠0 and frame_sync=1 (early sync): sync_err pulses and the partial frame is abandoned with no frame_done. The word is written to channel 0 with out_valid[0], counter becomes 1, state stays LOCKED (immediate resync).
- Holding registers keep their last value until overwritten. A partial or abandoned frame leaves the channels already written updated and the others stale.
- frame_done never coincides with sync_err.
- Reset asserted mid-frame: everything is cleared per the reset values above. After release, HUNT requires a new frame_sync.

Test Plan:
All scenarios use N_CH=4, W=8.
1. Reset then clean frame: in_valid=1 on consecutive cycles with words A0 (frame_sync=1), B1, C2, D3 -> out_valid pulses 0001, 0010, 0100, 1000 on successive cycles. out_data=0xD3C2B1A0 after the last pulse, frame_done pulses with out_valid[3], locked=1 from the cycle after A0, sync_err=0.
2. Hunt rejection: after reset, words 0x11, 0x22 without sync, then 0x33 with sync -> no strobes for the first two, locked=0 throughout them. 0x33 lands in channel 0 with out_valid[0]=1 and locked rises.
3. Gapped input: a frame with in_valid low for 3 cycles between slot 1 and slot 2 -> registers and counter hold across the gap, no strobes during it, slot 2 word lands in channel 2, frame_done still fires on slot 3.
4. Early sync: lock, write slots 0 and 1, then send 0x55 with frame_sync=1 -> sync_err pulses, 0x55 in channel 0 with out_valid[0], no frame_done. The following words fill channels 1..3 and frame_done fires.
5. Missing sync: complete one frame, then send 0x66 with frame_sync=0 -> sync_err pulses, locked=0, no out_valid, channel 0 keeps its old value. A subsequent synced word relocks.
6. Asynchronous reset mid-frame: assert rst_n=0 between clock edges after slot 2 -> outputs are zero before the next edge. After release, unsynced words are dropped until frame_sync is seen.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: receives a word-serial TDM stream, hunts for and locks to the
// frame-sync marker on slot 0, and steers each slot's word into its own holding register.
// Every output is registered, giving one cycle of latency from an accepted word to its strobe.
module tdm_demux #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int unsigned CntW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CntW-1:0] LastSlot = CntW'(N_CH - 1);
  localparam logic [CntW-1:0] SlotOne  = CntW'(1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_CH*W-1:0]   data_q, data_d;
  logic [N_CH-1:0]     valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Write request decoded from the current word, consumed by the holding-register update
  logic                wr_en;
  logic [CntW-1:0]     wr_ch;

  // State, slot counter, holding registers and strobes; async reset clears all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: alignment tracking, slot counting and per-word write decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_ch   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          // Unsynced words are dropped until a slot-0 marker is seen
          if (frame_sync) begin
            wr_en   = 1'b1;
            wr_ch   = '0;
            cnt_d   = SlotOne;
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (frame_sync) begin
            // Sync on slot 0 is a normal frame start; anywhere else abandons the partial
            // frame and resyncs immediately on this word
            wr_en = 1'b1;
            wr_ch = '0;
            cnt_d = SlotOne;
            err_d = (cnt_q != '0);
          end else if (cnt_q == '0) begin
            // Missing sync: drop the word and go back to hunting
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = StHunt;
          end else begin
            wr_en = 1'b1;
            wr_ch = cnt_q;
            if (cnt_q == LastSlot) begin
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + SlotOne;
            end
          end
        end
        default: begin
          state_d = StHunt;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding-register update and one-hot valid strobe for the selected channel
  always_comb begin
    data_d  = data_q;
    valid_d = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (wr_en && (wr_ch == CntW'(k))) begin
        data_d[k*W +: W] = in_data;
        valid_d[k]       = 1'b1;
      end
    end
  end

  // Outputs: straight from registers so they clear as soon as reset asserts
  always_comb begin
    out_data   = data_q;
    out_valid  = valid_q;
    frame_done = done_q;
    sync_err   = err_q;
    locked     = (state_q == StLocked);
  end

`ifndef SYNTHESIS
  // Strobe sanity: at most one channel strobe, and a frame never completes on an error
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(valid_q))
        else $error("out_valid has more than one bit set");
      assert (!(done_q && err_q))
        else $error("frame_done coincides with sync_err");
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8): a vector table covering clean, gapped,
// early-sync and missing-sync frames, then a hand-written async-reset and hunt sequence.
module tb_tdm_demux;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 8;

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  int n_checks;
  int n_errs;

  typedef struct {
    logic        v;
    logic        fs;
    logic [7:0]  d;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic        edone;
    logic        eerr;
    logic        elock;
  } vec_t;

  vec_t tbl[22];

  tdm_demux #(
    .N_CH(N_CH),
    .W   (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .frame_sync(frame_sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic fs, logic [7:0] d, logic [3:0] ev,
                              logic [31:0] ed, logic dn, logic er, logic lk);
    vec_t r;
    r.v = v; r.fs = fs; r.d = d; r.ev = ev; r.ed = ed;
    r.edone = dn; r.eerr = er; r.elock = lk;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " out_valid"}, 32'(out_valid), 32'(e.ev));
    check({tag, " out_data"}, out_data, e.ed);
    check({tag, " frame_done"}, 32'(frame_done), 32'(e.edone));
    check({tag, " sync_err"}, 32'(sync_err), 32'(e.eerr));
    check({tag, " locked"}, 32'(locked), 32'(e.elock));
  endtask

  // Drive one cycle of input between edges, then sample just after the rising edge
  task automatic apply(input string tag, input vec_t e);
    @(negedge clk);
    in_valid   = e.v;
    frame_sync = e.fs;
    in_data    = e.d;
    @(posedge clk);
    #1;
    check_all(tag, e);
  endtask

  initial begin
    n_checks   = 0;
    n_errs     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
    in_data    = '0;

    // Clean frame
    tbl[0]  = mk(1, 1, 8'hA0, 4'b0001, 32'h000000A0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 8'hB1, 4'b0010, 32'h0000B1A0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 8'hC2, 4'b0100, 32'h00C2B1A0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 8'hD3, 4'b1000, 32'hD3C2B1A0, 1, 0, 1);
    // Gapped frame: idle cycles carry junk and a sync that must be ignored
    tbl[4]  = mk(1, 1, 8'h10, 4'b0001, 32'hD3C2B110, 0, 0, 1);
    tbl[5]  = mk(1, 0, 8'h11, 4'b0010, 32'hD3C21110, 0, 0, 1);
    tbl[6]  = mk(0, 1, 8'hFF, 4'b0000, 32'hD3C21110, 0, 0, 1);
    tbl[7]  = mk(0, 0, 8'hEE, 4'b0000, 32'hD3C21110, 0, 0, 1);
    tbl[8]  = mk(0, 1, 8'hDD, 4'b0000, 32'hD3C21110, 0, 0, 1);
    tbl[9]  = mk(1, 0, 8'h12, 4'b0100, 32'hD3121110, 0, 0, 1);
    tbl[10] = mk(1, 0, 8'h13, 4'b1000, 32'h13121110, 1, 0, 1);
    // Early sync on slot 2 resyncs, then the new frame completes
    tbl[11] = mk(1, 1, 8'h20, 4'b0001, 32'h13121120, 0, 0, 1);
    tbl[12] = mk(1, 0, 8'h21, 4'b0010, 32'h13122120, 0, 0, 1);
    tbl[13] = mk(1, 1, 8'h55, 4'b0001, 32'h13122155, 0, 1, 1);
    tbl[14] = mk(1, 0, 8'h22, 4'b0010, 32'h13122255, 0, 0, 1);
    tbl[15] = mk(1, 0, 8'h23, 4'b0100, 32'h13232255, 0, 0, 1);
    tbl[16] = mk(1, 0, 8'h24, 4'b1000, 32'h24232255, 1, 0, 1);
    // Missing sync on slot 0 drops lock; hunting drops unsynced words; sync relocks
    tbl[17] = mk(1, 0, 8'h66, 4'b0000, 32'h24232255, 0, 1, 0);
    tbl[18] = mk(1, 0, 8'h77, 4'b0000, 32'h24232255, 0, 0, 0);
    tbl[19] = mk(1, 1, 8'h70, 4'b0001, 32'h24232270, 0, 0, 1);
    tbl[20] = mk(1, 0, 8'h71, 4'b0010, 32'h24237170, 0, 0, 1);
    tbl[21] = mk(1, 0, 8'h72, 4'b0100, 32'h24727170, 0, 0, 1);

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", mk(0, 0, 8'h00, 4'b0000, 32'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Async reset between edges, right after slot 2 strobed; outputs must clear at once
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", mk(0, 0, 8'h00, 4'b0000, 32'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Hunt after reset: the old mid-frame position is gone, unsynced words are dropped
    apply("hunt0", mk(1, 0, 8'h11, 4'b0000, 32'h0, 0, 0, 0));
    apply("hunt1", mk(1, 0, 8'h22, 4'b0000, 32'h0, 0, 0, 0));
    apply("hunt_idle", mk(0, 1, 8'h99, 4'b0000, 32'h0, 0, 0, 0));
    apply("hunt_lock", mk(1, 1, 8'h33, 4'b0001, 32'h00000033, 0, 0, 1));
    apply("hunt_s1", mk(1, 0, 8'h44, 4'b0010, 32'h00004433, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
